// File: rtl/rr_mux_arbiter_pkg.sv
// Shared constants and types for the four-way round-robin mux arbiter.
// Holds the state encoding and the index/one-hot helpers.
package rr_mux_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  function automatic logic [NUM_REQ-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux4to1.sv
// Plain four-input data mux; sel picks which input drives out.
module mux4to1 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] out
);

  always_comb begin
    out = in0;
    case (sel)
      2'd0: out = in0;
      2'd1: out = in1;
      2'd2: out = in2;
      2'd3: out = in3;
      default: out = in0;
    endcase
  end

endmodule

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set req bit at or above ptr,
// wrapping 3->0.
module rr_pick4
  import rr_mux_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] cand;

  // Scan from the farthest offset down so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      cand = ptr + IDX_W'(i);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one datapath among four requesters, with a
// bounded burst per grant and a valid/ready handshake downstream.
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [WIDTH-1:0]   in0,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  input  logic [WIDTH-1:0]   in3,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   address
);

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_e             state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [IDX_W-1:0]   address_q;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [3:0]         hold_cnt_q;

  logic               busy;
  logic               owner_req;
  logic               xfer;
  logic               release_own;
  logic [IDX_W-1:0]   pick_ptr;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;

  assign busy      = (state_q == ST_BUSY);
  assign owner_req = req[address_q];
  assign out_valid = busy & owner_req;
  assign xfer      = out_valid & out_ready;

  assign release_own = busy & (~owner_req | (xfer & (hold_cnt_q == HOLD_LAST)));

  // On release the search starts just past the owner, so it lands last.
  assign pick_ptr = busy ? (address_q + IDX_W'(1)) : rr_ptr_q;

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      address_q  <= '0;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_found) begin
            state_q    <= ST_BUSY;
            address_q  <= pick_idx;
            grant_q    <= idx2onehot(pick_idx);
            hold_cnt_q <= '0;
          end
        end
        ST_BUSY: begin
          if (release_own) begin
            rr_ptr_q   <= pick_ptr;
            hold_cnt_q <= '0;
            if (pick_found) begin
              address_q <= pick_idx;
              grant_q   <= idx2onehot(pick_idx);
            end else begin
              state_q   <= ST_IDLE;
              address_q <= '0;
              grant_q   <= '0;
            end
          end else if (xfer) begin
            hold_cnt_q <= hold_cnt_q + 4'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign grant   = grant_q;
  assign address = address_q;

  mux4to1 #(.WIDTH(WIDTH)) u_mux (
    .in0 (in0),
    .in1 (in1),
    .in2 (in2),
    .in3 (in3),
    .sel (address_q),
    .out (out_data)
  );

endmodule
